// File: rtl/run_monitor_if.sv
// run_monitor_if: control, snoop and result signals between a run_monitor and its user.
// Parameters: DATAWIDTH (watched value width), CNT_WIDTH (counter and limit width).
// master: drives start/limit/watch and the memory handshake snoops, reads status and counters.
// slave:  the monitor side.
interface run_monitor_if #(
    parameter int DATAWIDTH = 32,
    parameter int CNT_WIDTH = 32
);
    logic                 MON_Start_In;
    logic [CNT_WIDTH-1:0] MON_Limit_InBUS;
    logic [DATAWIDTH-1:0] MON_Watch_InBUS;
    logic                 MON_Insmem_Ready_In;
    logic                 MON_Insmem_Valid_In;
    logic                 MON_Datamem_Rd_Ready_In;
    logic                 MON_Datamem_Rd_Valid_In;
    logic                 MON_Datamem_Wr_Valid_In;
    logic                 MON_Datamem_Wr_Ready_In;
    logic                 MON_Busy_Out;
    logic                 MON_Done_Out;
    logic                 MON_Pass_Out;
    logic                 MON_Timeout_Out;
    logic [CNT_WIDTH-1:0] MON_Cycles_OutBUS;
    logic [CNT_WIDTH-1:0] MON_Fetches_OutBUS;
    logic [CNT_WIDTH-1:0] MON_Loads_OutBUS;
    logic [CNT_WIDTH-1:0] MON_Stores_OutBUS;
    logic [CNT_WIDTH-1:0] MON_Stalls_OutBUS;
    modport master (
        output MON_Start_In, MON_Limit_InBUS, MON_Watch_InBUS,
               MON_Insmem_Ready_In, MON_Insmem_Valid_In,
               MON_Datamem_Rd_Ready_In, MON_Datamem_Rd_Valid_In,
               MON_Datamem_Wr_Valid_In, MON_Datamem_Wr_Ready_In,
        input  MON_Busy_Out, MON_Done_Out, MON_Pass_Out, MON_Timeout_Out,
               MON_Cycles_OutBUS, MON_Fetches_OutBUS, MON_Loads_OutBUS,
               MON_Stores_OutBUS, MON_Stalls_OutBUS
    );
    modport slave (
        input  MON_Start_In, MON_Limit_InBUS, MON_Watch_InBUS,
               MON_Insmem_Ready_In, MON_Insmem_Valid_In,
               MON_Datamem_Rd_Ready_In, MON_Datamem_Rd_Valid_In,
               MON_Datamem_Wr_Valid_In, MON_Datamem_Wr_Ready_In,
        output MON_Busy_Out, MON_Done_Out, MON_Pass_Out, MON_Timeout_Out,
               MON_Cycles_OutBUS, MON_Fetches_OutBUS, MON_Loads_OutBUS,
               MON_Stores_OutBUS, MON_Stalls_OutBUS
    );
endinterface

// File: rtl/run_monitor.sv
// run_monitor: end-of-run signature detector, cycle watchdog and saturating memory-event counters.
// Ports: MON_Clk_In    clock, rising edge
//        MON_Reset_In  synchronous active-low reset
//        bus           run_monitor_if slave: start/limit/watch and passive memory handshake snoops in;
//                      busy/done/pass/timeout status and cycle/fetch/load/store/stall counters out.
module run_monitor #(
    parameter int                   DATAWIDTH     = 32,
    parameter int                   CNT_WIDTH     = 32,
    parameter int                   CYCLE_LIMIT   = 5000,
    parameter logic [DATAWIDTH-1:0] END_SIGNATURE = '1
) (
    input logic          MON_Clk_In,
    input logic          MON_Reset_In,
    run_monitor_if.slave bus
);
    // A default limit too large for the counters is clamped to all-ones so it still times out.
    localparam longint LIM_MAX = (longint'(1) << CNT_WIDTH) - 1;
    localparam logic [CNT_WIDTH-1:0] DEF_LIMIT =
        CNT_WIDTH'((longint'(CYCLE_LIMIT) > LIM_MAX) ? LIM_MAX : longint'(CYCLE_LIMIT));

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_TIMEOUT} state_t;

    state_t               r_state, w_next;
    logic                 w_start;
    logic                 r_done;
    logic [CNT_WIDTH-1:0] r_limit, r_cycles, r_fetches, r_loads, r_stores, r_stalls;
    logic                 w_fetch, w_load, w_store, w_stall;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic e);
        return (e && v != '1) ? v + 1'b1 : v;
    endfunction

    assign w_fetch = bus.MON_Insmem_Ready_In & bus.MON_Insmem_Valid_In;
    assign w_stall = bus.MON_Insmem_Ready_In & ~bus.MON_Insmem_Valid_In;
    assign w_load  = bus.MON_Datamem_Rd_Ready_In & bus.MON_Datamem_Rd_Valid_In;
    assign w_store = bus.MON_Datamem_Wr_Valid_In & bus.MON_Datamem_Wr_Ready_In;

    // The signature check comes first so a match on the final allowed cycle ends as PASS.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        if (r_state == S_RUN) begin
            if (bus.MON_Watch_InBUS == END_SIGNATURE)
                w_next = S_PASS;
            else if (r_cycles == r_limit - 1'b1)
                w_next = S_TIMEOUT;
        end else if (bus.MON_Start_In) begin
            w_next  = S_RUN;
            w_start = 1'b1;
        end
    end

    always_ff @(posedge MON_Clk_In) begin
        if (!MON_Reset_In)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge MON_Clk_In) begin
        if (!MON_Reset_In) begin
            r_done    <= 1'b0;
            r_limit   <= DEF_LIMIT;
            r_cycles  <= '0;
            r_fetches <= '0;
            r_loads   <= '0;
            r_stores  <= '0;
            r_stalls  <= '0;
        end else begin
            r_done <= (r_state == S_RUN) && (w_next != S_RUN);
            if (w_start) begin
                r_limit   <= (bus.MON_Limit_InBUS == '0) ? DEF_LIMIT : bus.MON_Limit_InBUS;
                r_cycles  <= '0;
                r_fetches <= '0;
                r_loads   <= '0;
                r_stores  <= '0;
                r_stalls  <= '0;
            end else if (r_state == S_RUN) begin
                r_cycles  <= sat_inc(r_cycles, 1'b1);
                r_fetches <= sat_inc(r_fetches, w_fetch);
                r_loads   <= sat_inc(r_loads, w_load);
                r_stores  <= sat_inc(r_stores, w_store);
                r_stalls  <= sat_inc(r_stalls, w_stall);
            end
        end
    end

    assign bus.MON_Busy_Out       = (r_state == S_RUN);
    assign bus.MON_Pass_Out       = (r_state == S_PASS);
    assign bus.MON_Timeout_Out    = (r_state == S_TIMEOUT);
    assign bus.MON_Done_Out       = r_done;
    assign bus.MON_Cycles_OutBUS  = r_cycles;
    assign bus.MON_Fetches_OutBUS = r_fetches;
    assign bus.MON_Loads_OutBUS   = r_loads;
    assign bus.MON_Stores_OutBUS  = r_stores;
    assign bus.MON_Stalls_OutBUS  = r_stalls;
endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: directed checks of run_monitor (32-bit default and a 4-bit-counter instance).
module tb_run_monitor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    run_monitor_if #(.DATAWIDTH(32), .CNT_WIDTH(32)) bus0 ();
    run_monitor_if #(.DATAWIDTH(32), .CNT_WIDTH(4))  bus4 ();

    run_monitor u0 (.MON_Clk_In(clk), .MON_Reset_In(rst_n), .bus(bus0.slave));
    run_monitor #(.CNT_WIDTH(4), .CYCLE_LIMIT(20)) u4 (.MON_Clk_In(clk), .MON_Reset_In(rst_n), .bus(bus4.slave));

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        bus0.MON_Start_In = 0; bus0.MON_Limit_InBUS = 0; bus0.MON_Watch_InBUS = 0;
        bus0.MON_Insmem_Ready_In = 0; bus0.MON_Insmem_Valid_In = 0;
        bus0.MON_Datamem_Rd_Ready_In = 0; bus0.MON_Datamem_Rd_Valid_In = 0;
        bus0.MON_Datamem_Wr_Valid_In = 0; bus0.MON_Datamem_Wr_Ready_In = 0;
        bus4.MON_Start_In = 0; bus4.MON_Limit_InBUS = 0; bus4.MON_Watch_InBUS = 0;
        bus4.MON_Insmem_Ready_In = 0; bus4.MON_Insmem_Valid_In = 0;
        bus4.MON_Datamem_Rd_Ready_In = 0; bus4.MON_Datamem_Rd_Valid_In = 0;
        bus4.MON_Datamem_Wr_Valid_In = 0; bus4.MON_Datamem_Wr_Ready_In = 0;
    endtask

    task automatic wait_done0(input int budget, output bit seen);
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step(1);
            seen = bus0.MON_Done_Out;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        bus0.MON_Start_In = 1;
        rst_n = 0;
        step(2);
        checks++;
        if ({bus0.MON_Busy_Out, bus0.MON_Done_Out, bus0.MON_Pass_Out, bus0.MON_Timeout_Out} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {bus0.MON_Busy_Out, bus0.MON_Done_Out, bus0.MON_Pass_Out, bus0.MON_Timeout_Out});
        end
        checks++;
        if ((bus0.MON_Cycles_OutBUS | bus0.MON_Fetches_OutBUS | bus0.MON_Loads_OutBUS | bus0.MON_Stores_OutBUS | bus0.MON_Stalls_OutBUS) !== 32'd0) begin
            failures++;
            $display("FAIL reset_counters got cycles=%0d fetches=%0d exp all 0", bus0.MON_Cycles_OutBUS, bus0.MON_Fetches_OutBUS);
        end
        checks++;
        if ({bus4.MON_Busy_Out, bus4.MON_Cycles_OutBUS} !== 5'd0) begin
            failures++;
            $display("FAIL reset_u4 got busy=%b cycles=%0d exp 0", bus4.MON_Busy_Out, bus4.MON_Cycles_OutBUS);
        end
        rst_n = 1;
        step(1);
        checks++;
        if (bus0.MON_Busy_Out !== 1'b1) begin
            failures++;
            $display("FAIL start_busy got=%b exp=1", bus0.MON_Busy_Out);
        end
        bus0.MON_Start_In = 0;
    endtask

    task automatic test_timeout_default();
        bit seen;
        wait_done0(6000, seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL timeout_done got=0 exp=1 within 6000 cycles");
        end
        checks++;
        if (bus0.MON_Cycles_OutBUS !== 32'd5000) begin
            failures++;
            $display("FAIL timeout_cycles got=%0d exp=5000", bus0.MON_Cycles_OutBUS);
        end
        checks++;
        if ({bus0.MON_Busy_Out, bus0.MON_Pass_Out, bus0.MON_Timeout_Out} !== 3'b001) begin
            failures++;
            $display("FAIL timeout_flags got=%b exp=001", {bus0.MON_Busy_Out, bus0.MON_Pass_Out, bus0.MON_Timeout_Out});
        end
        step(1);
        checks++;
        if ({bus0.MON_Done_Out, bus0.MON_Timeout_Out} !== 2'b01) begin
            failures++;
            $display("FAIL timeout_done_width got done,timeout=%b exp=01", {bus0.MON_Done_Out, bus0.MON_Timeout_Out});
        end
        bus0.MON_Watch_InBUS = 32'hFFFFFFFF;
        step(2);
        checks++;
        if ({bus0.MON_Pass_Out, bus0.MON_Timeout_Out, bus0.MON_Cycles_OutBUS} !== {2'b01, 32'd5000}) begin
            failures++;
            $display("FAIL watch_outside_run got pass=%b timeout=%b cycles=%0d exp 0,1,5000", bus0.MON_Pass_Out, bus0.MON_Timeout_Out, bus0.MON_Cycles_OutBUS);
        end
        bus0.MON_Watch_InBUS = 0;
    endtask

    task automatic test_pass_wins();
        bus0.MON_Limit_InBUS = 10;
        bus0.MON_Start_In = 1;
        step(1);
        bus0.MON_Start_In = 0;
        step(9);
        bus0.MON_Watch_InBUS = 32'hFFFFFFFF;
        step(1);
        bus0.MON_Watch_InBUS = 0;
        checks++;
        if ({bus0.MON_Done_Out, bus0.MON_Pass_Out, bus0.MON_Timeout_Out, bus0.MON_Busy_Out} !== 4'b1100) begin
            failures++;
            $display("FAIL pass_wins_flags got done,pass,timeout,busy=%b exp=1100", {bus0.MON_Done_Out, bus0.MON_Pass_Out, bus0.MON_Timeout_Out, bus0.MON_Busy_Out});
        end
        checks++;
        if (bus0.MON_Cycles_OutBUS !== 32'd10) begin
            failures++;
            $display("FAIL pass_wins_cycles got=%0d exp=10", bus0.MON_Cycles_OutBUS);
        end
        step(1);
        checks++;
        if ({bus0.MON_Done_Out, bus0.MON_Pass_Out, bus0.MON_Cycles_OutBUS} !== {2'b01, 32'd10}) begin
            failures++;
            $display("FAIL pass_hold got done=%b pass=%b cycles=%0d exp 0,1,10", bus0.MON_Done_Out, bus0.MON_Pass_Out, bus0.MON_Cycles_OutBUS);
        end
    endtask

    task automatic test_counters();
        bus0.MON_Limit_InBUS = 100;
        bus0.MON_Start_In = 1;
        step(1);
        bus0.MON_Start_In = 0;
        for (int k = 1; k <= 20; k++) begin
            bus0.MON_Insmem_Ready_In = 1;
            bus0.MON_Insmem_Valid_In = (k % 2 == 0);
            bus0.MON_Datamem_Rd_Ready_In = (k == 3 || k == 4 || k == 7 || k == 11);
            bus0.MON_Datamem_Rd_Valid_In = (k == 3 || k == 7 || k == 11 || k == 12);
            bus0.MON_Datamem_Wr_Valid_In = (k == 5 || k == 9 || k == 15);
            bus0.MON_Datamem_Wr_Ready_In = (k == 5 || k == 15 || k == 16);
            bus0.MON_Watch_InBUS = (k == 20) ? 32'hFFFFFFFF : 32'h0;
            step(1);
        end
        bus0.MON_Watch_InBUS = 0;
        bus0.MON_Datamem_Rd_Ready_In = 1; bus0.MON_Datamem_Rd_Valid_In = 1;
        bus0.MON_Datamem_Wr_Valid_In = 1; bus0.MON_Datamem_Wr_Ready_In = 1;
        bus0.MON_Insmem_Valid_In = 1;
        checks++;
        if ({bus0.MON_Fetches_OutBUS, bus0.MON_Stalls_OutBUS} !== {32'd10, 32'd10}) begin
            failures++;
            $display("FAIL count_fetch_stall got fetches=%0d stalls=%0d exp 10,10", bus0.MON_Fetches_OutBUS, bus0.MON_Stalls_OutBUS);
        end
        checks++;
        if ({bus0.MON_Loads_OutBUS, bus0.MON_Stores_OutBUS} !== {32'd3, 32'd2}) begin
            failures++;
            $display("FAIL count_load_store got loads=%0d stores=%0d exp 3,2", bus0.MON_Loads_OutBUS, bus0.MON_Stores_OutBUS);
        end
        checks++;
        if ({bus0.MON_Pass_Out, bus0.MON_Cycles_OutBUS} !== {1'b1, 32'd20}) begin
            failures++;
            $display("FAIL count_pass got pass=%b cycles=%0d exp 1,20", bus0.MON_Pass_Out, bus0.MON_Cycles_OutBUS);
        end
        step(3);
        checks++;
        if ({bus0.MON_Fetches_OutBUS, bus0.MON_Loads_OutBUS, bus0.MON_Stores_OutBUS} !== {32'd10, 32'd3, 32'd2}) begin
            failures++;
            $display("FAIL count_frozen got fetches=%0d loads=%0d stores=%0d exp 10,3,2", bus0.MON_Fetches_OutBUS, bus0.MON_Loads_OutBUS, bus0.MON_Stores_OutBUS);
        end
        idle_inputs();
    endtask

    task automatic test_reset_midrun();
        bit seen;
        bus0.MON_Limit_InBUS = 0;
        bus0.MON_Start_In = 1;
        step(1);
        bus0.MON_Start_In = 0;
        step(3);
        bus0.MON_Start_In = 1;
        step(1);
        bus0.MON_Start_In = 0;
        checks++;
        if ({bus0.MON_Busy_Out, bus0.MON_Cycles_OutBUS} !== {1'b1, 32'd4}) begin
            failures++;
            $display("FAIL start_in_run got busy=%b cycles=%0d exp 1,4", bus0.MON_Busy_Out, bus0.MON_Cycles_OutBUS);
        end
        step(2);
        rst_n = 0;
        step(1);
        rst_n = 1;
        checks++;
        if ({bus0.MON_Busy_Out, bus0.MON_Done_Out, bus0.MON_Timeout_Out, bus0.MON_Cycles_OutBUS} !== 35'd0) begin
            failures++;
            $display("FAIL midrun_reset got busy=%b done=%b timeout=%b cycles=%0d exp all 0", bus0.MON_Busy_Out, bus0.MON_Done_Out, bus0.MON_Timeout_Out, bus0.MON_Cycles_OutBUS);
        end
        step(1);
        checks++;
        if ({bus0.MON_Busy_Out, bus0.MON_Done_Out} !== 2'b00) begin
            failures++;
            $display("FAIL midrun_no_done got busy,done=%b exp=00", {bus0.MON_Busy_Out, bus0.MON_Done_Out});
        end
        bus0.MON_Limit_InBUS = 5;
        bus0.MON_Start_In = 1;
        step(1);
        bus0.MON_Start_In = 0;
        wait_done0(20, seen);
        checks++;
        if (!seen || bus0.MON_Cycles_OutBUS !== 32'd5 || bus0.MON_Timeout_Out !== 1'b1) begin
            failures++;
            $display("FAIL restart_limit5 got seen=%b cycles=%0d timeout=%b exp 1,5,1", seen, bus0.MON_Cycles_OutBUS, bus0.MON_Timeout_Out);
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        bus0.MON_Limit_InBUS = 3;
        bus0.MON_Start_In = 1;
        step(3);
        step(1);
        checks++;
        if ({bus0.MON_Done_Out, bus0.MON_Timeout_Out, bus0.MON_Cycles_OutBUS} !== {2'b11, 32'd3}) begin
            failures++;
            $display("FAIL b2b_first got done=%b timeout=%b cycles=%0d exp 1,1,3", bus0.MON_Done_Out, bus0.MON_Timeout_Out, bus0.MON_Cycles_OutBUS);
        end
        step(1);
        checks++;
        if ({bus0.MON_Busy_Out, bus0.MON_Done_Out, bus0.MON_Timeout_Out, bus0.MON_Cycles_OutBUS} !== {3'b100, 32'd0}) begin
            failures++;
            $display("FAIL b2b_rearm got busy=%b done=%b timeout=%b cycles=%0d exp 1,0,0,0", bus0.MON_Busy_Out, bus0.MON_Done_Out, bus0.MON_Timeout_Out, bus0.MON_Cycles_OutBUS);
        end
        bus0.MON_Start_In = 0;
        wait_done0(10, seen);
        checks++;
        if (!seen || bus0.MON_Cycles_OutBUS !== 32'd3) begin
            failures++;
            $display("FAIL b2b_second got seen=%b cycles=%0d exp 1,3", seen, bus0.MON_Cycles_OutBUS);
        end
        bus0.MON_Limit_InBUS = 1;
        bus0.MON_Start_In = 1;
        step(1);
        bus0.MON_Start_In = 0;
        step(1);
        checks++;
        if ({bus0.MON_Done_Out, bus0.MON_Timeout_Out, bus0.MON_Cycles_OutBUS} !== {2'b11, 32'd1}) begin
            failures++;
            $display("FAIL limit1 got done=%b timeout=%b cycles=%0d exp 1,1,1", bus0.MON_Done_Out, bus0.MON_Timeout_Out, bus0.MON_Cycles_OutBUS);
        end
    endtask

    task automatic test_saturation();
        bit seen = 0;
        bus4.MON_Limit_InBUS = 0;
        bus4.MON_Insmem_Ready_In = 1;
        bus4.MON_Insmem_Valid_In = 1;
        bus4.MON_Start_In = 1;
        step(1);
        bus4.MON_Start_In = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(1);
            seen = bus4.MON_Done_Out;
        end
        checks++;
        if (!seen || bus4.MON_Timeout_Out !== 1'b1) begin
            failures++;
            $display("FAIL sat_timeout got seen=%b timeout=%b exp 1,1", seen, bus4.MON_Timeout_Out);
        end
        checks++;
        if ({bus4.MON_Fetches_OutBUS, bus4.MON_Cycles_OutBUS, bus4.MON_Stalls_OutBUS} !== {4'd15, 4'd15, 4'd0}) begin
            failures++;
            $display("FAIL sat_counts got fetches=%0d cycles=%0d stalls=%0d exp 15,15,0", bus4.MON_Fetches_OutBUS, bus4.MON_Cycles_OutBUS, bus4.MON_Stalls_OutBUS);
        end
        step(2);
        checks++;
        if (bus4.MON_Fetches_OutBUS !== 4'd15) begin
            failures++;
            $display("FAIL sat_hold got=%0d exp=15", bus4.MON_Fetches_OutBUS);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_timeout_default();
        test_pass_wins();
        test_counters();
        test_reset_midrun();
        test_back_to_back();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
